// File: rtl/decim_sample_framer.sv
// Decimated sample framer: differences a free-running ones-count every
// DECIM_RATIO clocks and queues the window totals in a FWFT output FIFO.
module decim_sample_framer #(
  parameter int DATA_W      = 16,
  parameter int DECIM_RATIO = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        decimator_reset,
  input  logic                        enable,
  input  logic [DATA_W-1:0]           count_in,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        clear_overflow
);

  localparam int CNT_W = $clog2(DECIM_RATIO);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DECIM_RATIO - 1);
  localparam logic [PTR_W:0]   FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  dec_cnt;
  logic [DATA_W-1:0] prev_count;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;

  logic              tick;
  logic              push_req;
  logic              full;
  logic              pop;
  logic              do_push;
  logic              drop;
  logic [DATA_W-1:0] diff;

  // enable low has priority: a window boundary seen while dropping out is void
  assign tick     = enable && (state != IDLE) && (dec_cnt == LAST);
  assign push_req = tick && (state == RUN);
  assign diff     = count_in - prev_count;

  assign fifo_level = wr_ptr - rd_ptr;
  assign out_valid  = (fifo_level != '0);
  assign full       = (fifo_level == FULL);
  assign pop        = out_valid && out_ready;
  assign do_push    = push_req && (!full || pop);
  assign drop       = push_req && full && !pop;
  assign out_data   = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or posedge decimator_reset) begin
    if (decimator_reset) begin
      state      <= IDLE;
      dec_cnt    <= '0;
      prev_count <= '0;
    end else if (!enable) begin
      state   <= IDLE;
      dec_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          state   <= PRIME;
          dec_cnt <= '0;
        end
        PRIME: begin
          dec_cnt <= tick ? '0 : dec_cnt + CNT_W'(1);
          if (tick) begin
            prev_count <= count_in;
            state      <= RUN;
          end
        end
        RUN: begin
          dec_cnt <= tick ? '0 : dec_cnt + CNT_W'(1);
          if (tick) prev_count <= count_in;
        end
        default: begin
          state   <= IDLE;
          dec_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge decimator_reset) begin
    if (decimator_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PTR_W-1:0]] <= diff;
        wr_ptr                 <= wr_ptr + (PTR_W + 1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule
